// File: rtl/writeback_queue_if.sv
// Retire-side handshake, register-file write port and forwarding lookup for writeback_queue.
// slave is the queue's view of these signals; master is the view of the stage driving them.
interface writeback_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  immediate;
    logic [XLEN-1:0]  memory_result;
    logic [XLEN-1:0]  pc;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             rf_ready;
    logic [4:0]       query_addr;
    logic             query_hit;
    logic [XLEN-1:0]  query_data;
    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, opcode, funct3, rd, alu_result, immediate, memory_result, pc,
        input  rf_ready, query_addr,
        output in_ready, rf_we, rf_waddr, rf_wdata, query_hit, query_data, count
    );

    modport master (
        output in_valid, opcode, funct3, rd, alu_result, immediate, memory_result, pc,
        output rf_ready, query_addr,
        input  in_ready, rf_we, rf_waddr, rf_wdata, query_hit, query_data, count
    );
endinterface

// File: rtl/writeback_queue.sv
// Selects the writeback value of retiring instructions and queues the register-file writes in a
// DEPTH-entry FIFO. The FIFO drains in order under rf_ready and can be searched for forwarding.
module writeback_queue #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2,
    parameter int PC_INC = 4
) (
    input logic              clk,
    input logic              reset,
    writeback_queue_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Register-backed rather than RAM-backed: the forwarding search reads every entry at once.
    logic [4:0]      waddr_mem [DEPTH];
    logic [XLEN-1:0] wdata_mem [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic            is_wb_op;
    logic [XLEN-1:0] wb_value;
    logic            push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        is_wb_op = 1'b0;
        wb_value = bus.alu_result;
        case (bus.opcode)
            OPC_OP, OPC_OP_IMM, OPC_AUIPC: begin
                is_wb_op = 1'b1;
                wb_value = bus.alu_result;
            end
            OPC_LOAD: begin
                is_wb_op = 1'b1;
                case (bus.funct3)
                    3'b000:  wb_value = {{(XLEN-8){bus.memory_result[7]}}, bus.memory_result[7:0]};
                    3'b001:  wb_value = {{(XLEN-16){bus.memory_result[15]}}, bus.memory_result[15:0]};
                    3'b100:  wb_value = {{(XLEN-8){1'b0}}, bus.memory_result[7:0]};
                    3'b101:  wb_value = {{(XLEN-16){1'b0}}, bus.memory_result[15:0]};
                    default: wb_value = bus.memory_result;
                endcase
            end
            OPC_LUI: begin
                is_wb_op = 1'b1;
                wb_value = bus.immediate;
            end
            OPC_JAL, OPC_JALR: begin
                is_wb_op = 1'b1;
                wb_value = bus.pc + XLEN'(PC_INC);
            end
            default: begin
                is_wb_op = 1'b0;
                wb_value = bus.alu_result;
            end
        endcase
    end

    assign bus.rf_we    = (count_reg != '0);
    assign bus.rf_waddr = bus.rf_we ? waddr_mem[head_reg] : 5'd0;
    assign bus.rf_wdata = bus.rf_we ? wdata_mem[head_reg] : '0;
    assign bus.count    = count_reg;

    assign pop          = bus.rf_we && bus.rf_ready;
    assign bus.in_ready = (count_reg < CNT_W'(DEPTH)) || pop;
    // Non-writing instructions complete the handshake but never occupy an entry.
    assign push         = bus.in_valid && bus.in_ready && is_wb_op && (bus.rd != 5'd0);

    always_comb begin
        head_next  = pop  ? ptr_inc(head_reg) : head_reg;
        tail_next  = push ? ptr_inc(tail_reg) : tail_reg;
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            waddr_mem[tail_reg] <= bus.rd;
            wdata_mem[tail_reg] <= wb_value;
        end
    end

    // Per age offset: which slot holds it and whether it is an occupied match for the query.
    logic [PTR_W-1:0] slot_idx [DEPTH];
    logic [DEPTH-1:0] match_vec;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
            logic [PTR_W:0] slot_sum;
            assign slot_sum = {1'b0, head_reg} + (PTR_W+1)'(gi);
            assign slot_idx[gi] = (slot_sum >= (PTR_W+1)'(DEPTH))
                                ? PTR_W'(slot_sum - (PTR_W+1)'(DEPTH))
                                : PTR_W'(slot_sum);
            assign match_vec[gi] = (CNT_W'(gi) < count_reg)
                                && (waddr_mem[slot_idx[gi]] == bus.query_addr)
                                && (bus.query_addr != 5'd0);
        end
    endgenerate

    // Scanning oldest to youngest lets the youngest match overwrite earlier ones.
    always_comb begin
        bus.query_hit  = 1'b0;
        bus.query_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_vec[k]) begin
                bus.query_hit  = 1'b1;
                bus.query_data = wdata_mem[slot_idx[k]];
            end
        end
    end
endmodule
